// File: rtl/ef_uart_pkg.sv
// Shared constants for the UART receive path: default FIFO geometry and
// the width of the character-timeout counter.
package ef_uart_pkg;
    localparam int EF_UART_FIFO_DW = 8;
    localparam int EF_UART_FIFO_AW = 4;
    localparam int EF_UART_TO_W    = 6;
endpackage

// File: rtl/ef_uart_rx_timeout.sv
// Character-timeout tracker: counts idle bit periods while the RX FIFO holds
// data and flags when the idle time reaches the configured number of bits.
module ef_uart_rx_timeout
    import ef_uart_pkg::*;
(
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    activity,
    input  logic                    empty,
    input  logic                    baud_tick,
    input  logic                    flush,
    input  logic [EF_UART_TO_W-1:0] timeout_bits,
    output logic                    timeout
);

    logic [EF_UART_TO_W-1:0] timer_q;
    logic [EF_UART_TO_W-1:0] timer_d;
    logic                    idle_clr;
    logic                    timeout_d;

    assign idle_clr = activity || flush || empty;

    // The compare looks at the next timer value so the flag rises on the
    // same edge that the count reaches timeout_bits.
    always_comb begin
        // NOTE: every variable gets a default first so no latch is inferred.
        timer_d = timer_q;
        if (idle_clr) begin
            timer_d = '0;
        end else if (baud_tick && (timer_q != '1)) begin
            timer_d = timer_q + 1'b1;
        end
        timeout_d = !idle_clr && (timeout_bits != '0) && (timer_d >= timeout_bits);
    end

    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (RESET) begin
            timer_q <= '0;
            timeout <= 1'b0;
        end else begin
            timer_q <= timer_d;
            timeout <= timeout_d;
        end
    end

endmodule

// File: rtl/ef_uart_rx_fifo.sv
// First-word-fall-through receive FIFO between the UART receiver and the bus
// wrapper, with level/threshold flags, sticky overrun and character timeout.
module ef_uart_rx_fifo
    import ef_uart_pkg::*;
#(
    parameter int DW = EF_UART_FIFO_DW,
    parameter int AW = EF_UART_FIFO_AW
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    wr,
    input  logic [DW-1:0]           wdata,
    input  logic                    rd,
    output logic [DW-1:0]           rdata,
    input  logic                    flush,
    input  logic [AW-1:0]           threshold,
    input  logic [EF_UART_TO_W-1:0] timeout_bits,
    input  logic                    baud_tick,
    input  logic                    overrun_clr,
    output logic [AW:0]             level,
    output logic                    empty,
    output logic                    full,
    output logic                    above_thr,
    output logic                    overrun,
    output logic                    timeout
);

    localparam logic [AW:0] DEPTH = (AW+1)'(2**AW);

    logic [DW-1:0] mem [2**AW];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          wr_acc;
    logic          rd_acc;
    logic          wr_drop;

    assign empty     = (level == '0);
    assign full      = (level == DEPTH);
    assign above_thr = (level > {1'b0, threshold});
    assign rdata     = empty ? '0 : mem[rd_ptr];

    // A read frees a slot in the same cycle, so a full FIFO still accepts a
    // write paired with a read.
    assign wr_acc  = wr && (!full || rd);
    assign rd_acc  = rd && !empty;
    assign wr_drop = wr && full && !rd;

    // NOTE: the storage array has no reset; stale contents are never visible
    // because rdata is masked while empty and pointers restart at zero.
    always_ff @(posedge CLK) begin
        if (wr_acc && !flush) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
            if (wr_acc && !rd_acc) begin
                level <= level + 1'b1;
            end else if (rd_acc && !wr_acc) begin
                level <= level - 1'b1;
            end
        end
    end

    // Overrun survives flush; a new drop wins over a simultaneous clear.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            overrun <= 1'b0;
        end else if (wr_drop) begin
            overrun <= 1'b1;
        end else if (overrun_clr) begin
            overrun <= 1'b0;
        end
    end

    ef_uart_rx_timeout u_timeout (
        .CLK          (CLK),
        .RESET        (RESET),
        .activity     (wr_acc || rd_acc),
        .empty        (empty),
        .baud_tick    (baud_tick),
        .flush        (flush),
        .timeout_bits (timeout_bits),
        .timeout      (timeout)
    );

endmodule

// File: tb/tb_ef_uart_rx_fifo.sv
// Self-checking bench for ef_uart_rx_fifo: a byte queue scoreboard tracks
// expected contents, level and overrun; timeout and flags are checked directly.
module tb_ef_uart_rx_fifo;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       wr;
    logic [7:0] wdata;
    logic       rd;
    logic [7:0] rdata;
    logic       flush;
    logic [3:0] threshold;
    logic [5:0] timeout_bits;
    logic       baud_tick;
    logic       overrun_clr;
    logic [4:0] level;
    logic       empty;
    logic       full;
    logic       above_thr;
    logic       overrun;
    logic       timeout;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] sb[$];
    logic       ovr_m = 1'b0;

    always #5 CLK = ~CLK;

    ef_uart_rx_fifo dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .wr           (wr),
        .wdata        (wdata),
        .rd           (rd),
        .rdata        (rdata),
        .flush        (flush),
        .threshold    (threshold),
        .timeout_bits (timeout_bits),
        .baud_tick    (baud_tick),
        .overrun_clr  (overrun_clr),
        .level        (level),
        .empty        (empty),
        .full         (full),
        .above_thr    (above_thr),
        .overrun      (overrun),
        .timeout      (timeout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Applies the currently driven inputs for one clock, updating the model
    // and checking popped data before the edge and state after it.
    task automatic clk_step();
        int         sz;
        bit         full_m;
        bit         empty_m;
        logic [7:0] e;
        sz      = sb.size();
        full_m  = (sz == 16);
        empty_m = (sz == 0);
        if (RESET) begin
            sb.delete();
            ovr_m = 1'b0;
        end else begin
            if (wr && full_m && !rd) ovr_m = 1'b1;
            else if (overrun_clr)    ovr_m = 1'b0;
            if (flush) begin
                sb.delete();
            end else begin
                if (rd && !empty_m) begin
                    e = sb.pop_front();
                    check("rdata", {24'd0, rdata}, {24'd0, e});
                end
                if (wr && (!full_m || rd)) sb.push_back(wdata);
            end
        end
        @(posedge CLK);
        #1;
        check("level", {27'd0, level}, sb.size());
        check("empty", {31'd0, empty}, {31'd0, sb.size() == 0});
        check("full", {31'd0, full}, {31'd0, sb.size() == 16});
        check("overrun", {31'd0, overrun}, {31'd0, ovr_m});
        wr          = 1'b0;
        rd          = 1'b0;
        flush       = 1'b0;
        baud_tick   = 1'b0;
        overrun_clr = 1'b0;
        RESET       = 1'b0;
    endtask

    task automatic push(input logic [7:0] d);
        wr    = 1'b1;
        wdata = d;
        clk_step();
    endtask

    task automatic pop();
        rd = 1'b1;
        clk_step();
    endtask

    initial begin
        wr = 0; wdata = 0; rd = 0; flush = 0; baud_tick = 0; overrun_clr = 0;
        threshold = 4'd15; timeout_bits = 6'd0;

        RESET = 1'b1; clk_step();
        RESET = 1'b1; clk_step();
        check("rst_rdata", {24'd0, rdata}, 32'd0);
        check("rst_timeout", {31'd0, timeout}, 32'd0);
        check("rst_above_thr", {31'd0, above_thr}, 32'd0);

        // Basic write/read
        push(8'hA5);
        check("head_after_wr", {24'd0, rdata}, 32'hA5);
        push(8'h3C);
        pop();
        pop();
        check("rdata_empty", {24'd0, rdata}, 32'd0);
        pop();

        // Full, overrun, clear, in-order drain
        for (int i = 0; i < 16; i++) push(8'(i));
        push(8'hFF);
        check("ovr_set", {31'd0, overrun}, 32'd1);
        overrun_clr = 1'b1; clk_step();
        check("ovr_clr", {31'd0, overrun}, 32'd0);
        for (int i = 0; i < 16; i++) pop();

        // Simultaneous wr/rd while full
        for (int i = 0; i < 16; i++) push(8'(8'h20 + i));
        wr = 1'b1; wdata = 8'h55; rd = 1'b1; clk_step();
        check("simul_level", {27'd0, level}, 32'd16);
        for (int i = 0; i < 15; i++) pop();
        check("simul_last", {24'd0, rdata}, 32'h55);
        pop();

        // Simultaneous wr/rd while empty: only the write lands
        wr = 1'b1; wdata = 8'h66; rd = 1'b1; clk_step();
        check("wr_rd_empty", {27'd0, level}, 32'd1);
        pop();

        // Threshold and flush
        threshold = 4'd3;
        for (int i = 0; i < 4; i++) begin
            push(8'(8'h40 + i));
            check("above_thr", {31'd0, above_thr}, {31'd0, (i + 1) > 3});
        end
        wr = 1'b1; wdata = 8'h99; flush = 1'b1; clk_step();
        check("flush_level", {27'd0, level}, 32'd0);

        // Timeout with two bytes buffered
        timeout_bits = 6'd4;
        push(8'h77);
        push(8'h78);
        for (int i = 1; i <= 4; i++) begin
            baud_tick = 1'b1; clk_step();
            check("timeout_tick", {31'd0, timeout}, {31'd0, i >= 4});
        end
        pop();
        check("timeout_rd_clr", {31'd0, timeout}, 32'd0);
        pop();

        // Disabled timeout, then enabling it mid-count
        timeout_bits = 6'd0;
        push(8'h9A);
        for (int i = 0; i < 63; i++) begin
            baud_tick = 1'b1; clk_step();
            check("timeout_off", {31'd0, timeout}, 32'd0);
        end
        timeout_bits = 6'd4; clk_step();
        check("timeout_live_bits", {31'd0, timeout}, 32'd1);
        pop();
        check("timeout_empty", {31'd0, timeout}, 32'd0);

        // Reset mid-operation with level 5 and overrun set
        for (int i = 0; i < 16; i++) push(8'(8'h80 + i));
        push(8'hEE);
        for (int i = 0; i < 11; i++) pop();
        check("pre_rst_level", {27'd0, level}, 32'd5);
        check("pre_rst_ovr", {31'd0, overrun}, 32'd1);
        RESET = 1'b1; clk_step();
        check("mid_rst_rdata", {24'd0, rdata}, 32'd0);
        check("mid_rst_above", {31'd0, above_thr}, 32'd0);
        check("mid_rst_timeout", {31'd0, timeout}, 32'd0);
        push(8'h12);
        check("post_rst_head", {24'd0, rdata}, 32'h12);
        pop();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ef_uart_rx_fifo.md
Name: ef_uart_rx_fifo

Overview:
- Receive-side buffer directly downstream of the UART receiver core.
- Captures each byte presented on the receiver's rx_done strobe and holds it for the bus wrapper (APB/AHBL) to read.
- Reports fill level, threshold crossing, overrun, and a character-timeout condition, which the wrapper routes to IRQ.

Parameters:
DW, 8, data width of one received character
AW, 4, address width; depth = 2**AW entries (16)

Ports:
CLK  input  1  system clock; all logic on rising edge
RESET  input  1  synchronous, active-high reset
wr  input  1  write strobe, 1-cycle pulse from receiver rx_done
wdata  input  DW  received character, valid when wr=1
rd  input  1  read/pop strobe from bus wrapper
rdata  output  DW  head-of-FIFO character (first-word-fall-through)
flush  input  1  synchronous clear of contents
threshold  input  AW  level threshold from config register
timeout_bits  input  6  idle bit-times before timeout; 0 disables
baud_tick  input  1  one pulse per bit period, from the receiver's baud generator
overrun_clr  input  1  clears sticky overrun
level  output  AW+1  number of stored entries, 0..2**AW
empty  output  1  level==0
full  output  1  level==2**AW
above_thr  output  1  level > threshold
overrun  output  1  sticky: a write was dropped
timeout  output  1  character timeout active

Behaviour:
- Reset values: level=0, empty=1, full=0, above_thr=0, overrun=0, timeout=0, rdata=0. Pointers are 0 and counters are 0.
- Storage:
  - Register array of 2**AW x DW.
  - wr_ptr and rd_ptr are AW bits and wrap naturally from 2**AW-1 to 0.
  - level is a separate AW+1-bit counter.
- rdata = mem[rd_ptr] combinationally when !empty, else 0. No read latency.
- Write latency: a wr at cycle N updates level/empty/full at the edge ending cycle N. The data is visible on rdata in cycle N+1.
- Accepted write: wr && (!full || rd). Accepted read: rd && !empty.
- Simultaneous events:
  - wr && rd while full: both accepted; level stays 2**AW; no overrun.
  - wr && rd while empty: write accepted, read ignored; level becomes 1.
  - wr && rd otherwise: both accepted; level unchanged.
- rd while empty: ignored; no state change.
- wr while full (no rd): data dropped; overrun set to 1; pointers and level unchanged.
- Overrun priority: set beats overrun_clr in the same cycle; otherwise overrun_clr clears it.
- flush beats wr and rd in the same cycle:
  - pointers=0, level=0, timeout=0, timer=0.
  - overrun is NOT affected by flush.
- Flags are combinational decodes of registered level: empty, full, above_thr (level > threshold, unsigned, threshold zero-extended).
- Timeout timer (6-bit counter):
  - Clears to 0 on any accepted write, accepted read, flush, or when empty.
  - Otherwise increments on baud_tick, saturating at 63.
  - timeout = 1 when !empty && timeout_bits != 0 && timer >= timeout_bits. It is registered, i.e. set on the edge where the compare first holds.
  - timeout drops at the edge following the next accepted wr, accepted rd, or flush.
  - Changing timeout_bits mid-count takes effect immediately in the compare.
- RESET asserted mid-operation: all state returns to reset values on that edge. Contents are discarded (memory need not be cleared).

Decomposition:
- Shared package ef_uart_pkg:
  - defaults EF_UART_FIFO_DW=8, EF_UART_FIFO_AW=4
  - EF_UART_TO_W=6 (timeout counter width)
- One natural sub-module: ef_uart_rx_timeout, holding the timer, its clear/increment logic, and the timeout register. Inputs: activity, empty, baud_tick, timeout_bits, flush.
- Pointers, array and flags stay in ef_uart_rx_fifo.

Test Plan:
- Basic:
  - Stimulus: after reset, write 0xA5 then 0x3C, then rd twice.
  - Response: rdata=0xA5 the cycle after the first wr; level goes 1,2,1,0; empty=1 at the end; rdata=0.
- Full/overrun:
  - Stimulus: write 16 bytes 0x00..0x0F; write 0xFF; then pulse overrun_clr.
  - Response: full=1, level=16, overrun=1, and the FIFO still reads back 0x00..0x0F in order. overrun_clr returns overrun to 0.
- Simultaneous:
  - Stimulus: fill to 16, then wr=0x55 with rd in the same cycle.
  - Response: level stays 16, overrun=0, and the last entry read back is 0x55.
- Threshold and flush:
  - Stimulus: threshold=3; write 4 bytes.
  - Response: above_thr=1 only after the 4th write.
  - Stimulus: flush together with wr.
  - Response: level=0, empty=1, overrun unchanged.
- Timeout:
  - Stimulus: timeout_bits=4; write 1 byte; send 4 baud_ticks.
  - Response: timeout=1 after the 4th tick; a rd clears it next edge.
  - Stimulus: timeout_bits=0 with 63 ticks.
  - Response: timeout stays 0.
- Reset mid-operation:
  - Stimulus: with level=5 and overrun=1, assert RESET for 1 cycle.
  - Response: all outputs at reset values on the next cycle.
